// File: rtl/div_issue_ctrl_if.sv
// div_issue_ctrl_if: bundle for the divider issue/capture stage.
// Request (in_*), divider link (div_*) and result (out_*, flags) signals.
interface div_issue_ctrl_if #(
  parameter int WIDTH = 16
);
  logic             in_valid;
  logic             in_ready;
  logic             in_signed;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic [WIDTH-1:0] div_dividend;
  logic [WIDTH-1:0] div_divisor;
  logic [WIDTH-1:0] div_quotient;
  logic [WIDTH-1:0] div_remainder;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] quotient;
  logic [WIDTH-1:0] remainder;
  logic             div_by_zero;
  logic             overflow;

  modport master (
    output in_valid, in_signed, a, b,
    output div_quotient, div_remainder,
    output out_ready,
    input  in_ready, div_dividend, div_divisor,
    input  out_valid, quotient, remainder,
    input  div_by_zero, overflow
  );

  modport slave (
    input  in_valid, in_signed, a, b,
    input  div_quotient, div_remainder,
    input  out_ready,
    output in_ready, div_dividend, div_divisor,
    output out_valid, quotient, remainder,
    output div_by_zero, overflow
  );
endinterface

// File: rtl/div_issue_ctrl.sv
// div_issue_ctrl: feeds operand magnitudes to an unsigned divider, sign-fixes results.
// Ports: clk, rst (async, active-high), bus (slave): in_* req, div_* divider, out_* result.
module div_issue_ctrl #(
  parameter int WIDTH   = 16,
  parameter int DIV_LAT = 1
) (
  input logic             clk,
  input logic             rst,
  div_issue_ctrl_if.slave bus
);
  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] WAIT = 2'd1;
  localparam logic [1:0] DONE = 2'd2;

  localparam int CW = (DIV_LAT < 2) ? 1 : $clog2(DIV_LAT + 1);
  localparam logic [CW-1:0] CNT_INIT = CW'(DIV_LAT);
  localparam logic [CW-1:0] CNT_ONE  = CW'(1);

  localparam logic [WIDTH-1:0] MOST_NEG = {1'b1, {(WIDTH-1){1'b0}}};
  localparam logic [WIDTH-1:0] ALL_ONES = '1;

  logic [1:0]       state;
  logic [CW-1:0]    cnt;
  logic             neg_q;
  logic             neg_r;
  logic             zero;
  logic             ovf;
  logic [WIDTH-1:0] dd;
  logic [WIDTH-1:0] dv;
  logic [WIDTH-1:0] q;
  logic [WIDTH-1:0] r;
  logic             dz;
  logic             ov;

  logic             accept;
  logic             a_neg;
  logic             b_neg;
  logic [WIDTH-1:0] a_mag;
  logic [WIDTH-1:0] b_mag;
  logic [WIDTH-1:0] q_fix;
  logic [WIDTH-1:0] r_fix;

  // Magnitude of the most-negative value wraps to itself, which is the
  // right unsigned magnitude for the divider.
  always_comb begin
    accept = bus.in_valid && (state == IDLE);
    a_neg  = bus.in_signed && bus.a[WIDTH-1];
    b_neg  = bus.in_signed && bus.b[WIDTH-1];
    a_mag  = a_neg ? -bus.a : bus.a;
    b_mag  = b_neg ? -bus.b : bus.b;
    q_fix  = neg_q ? -bus.div_quotient : bus.div_quotient;
    r_fix  = neg_r ? -bus.div_remainder : bus.div_remainder;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      cnt   <= '0;
      neg_q <= 1'b0;
      neg_r <= 1'b0;
      zero  <= 1'b0;
      ovf   <= 1'b0;
      dd    <= '0;
      dv    <= '0;
      q     <= '0;
      r     <= '0;
      dz    <= 1'b0;
      ov    <= 1'b0;
    end else begin
      unique case (state)
        IDLE: begin
          if (accept) begin
            dd    <= a_mag;
            dv    <= b_mag;
            neg_q <= a_neg ^ b_neg;
            neg_r <= a_neg;
            zero  <= (bus.b == '0);
            ovf   <= bus.in_signed
                     && (bus.a == MOST_NEG)
                     && (bus.b == ALL_ONES);
            cnt   <= CNT_INIT;
            state <= WAIT;
          end
        end
        WAIT: begin
          cnt <= cnt - CNT_ONE;
          // Divider output is valid on the edge the count hits zero.
          if (cnt == CNT_ONE) begin
            state <= DONE;
            if (zero) begin
              q  <= '0;
              r  <= '0;
              dz <= 1'b1;
              ov <= 1'b0;
            end else if (ovf) begin
              q  <= MOST_NEG;
              r  <= '0;
              dz <= 1'b0;
              ov <= 1'b1;
            end else begin
              q  <= q_fix;
              r  <= r_fix;
              dz <= 1'b0;
              ov <= 1'b0;
            end
          end
        end
        DONE: begin
          // Flags drop with the handshake; data stays visible.
          if (bus.out_ready) begin
            state <= IDLE;
            dz    <= 1'b0;
            ov    <= 1'b0;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.in_ready     = (state == IDLE);
  assign bus.out_valid    = (state == DONE);
  assign bus.div_dividend = dd;
  assign bus.div_divisor  = dv;
  assign bus.quotient     = q;
  assign bus.remainder    = r;
  assign bus.div_by_zero  = dz;
  assign bus.overflow     = ov;
endmodule
